strober_shift: RTL and testbench

Periodic strobe generator feeding a serial-in/parallel-out shift register, producing a rotating one-hot pattern for sequencing LED columns. A free-running modulo-PERIOD counter asserts a one-cycle strobe `d` every PERIOD clocks, starting on the first cycle after reset. The strobe is shifted into a WIDTH-bit register at the LSB, so with WIDTH == PERIOD, `q` walks 1, 2, 4, … 2^(WIDTH-1) and wraps back to 1.

---
 rtl/strober_shift.sv | 52 +++++
 tb/tb_strober_shift.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/strober_shift.sv
// Periodic strobe (d high once every PERIOD clocks) shifted into a WIDTH-bit SIPO register.
// Optional advance enable input 'en' is added when STROBER_SHIFT_ENABLE_EN is defined.
module strober_shift #(
   parameter int WIDTH  = 6,
   parameter int PERIOD = 6
) (
   input  logic             clk,
   input  logic             rst_n,
`ifdef STROBER_SHIFT_ENABLE_EN
   input  logic             en,
`endif
   output logic             d,
   output logic [WIDTH-1:0] q
);

   localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(PERIOD - 1);

   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] shift_q, shift_d;
   logic             adv;

`ifdef STROBER_SHIFT_ENABLE_EN
   assign adv = en;
`else
   assign adv = 1'b1;
`endif

   // Strobe decodes straight from the counter flop, so it only moves at clock edges.
   assign d = (cnt_q == '0);
   assign q = shift_q;

   always_comb begin
      cnt_d   = cnt_q;
      shift_d = shift_q;
      if (adv) begin
         cnt_d   = (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);
         shift_d = {shift_q[WIDTH-2:0], d};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q   <= '0;
         shift_q <= '0;
      end else begin
         cnt_q   <= cnt_d;
         shift_q <= shift_d;
      end
   end

endmodule

// File: tb/tb_strober_shift.sv
// Bench for strober_shift: directed walk/strobe/reset/enable checks plus a random phase,
// compared against an arithmetic model of edges-since-reset (6/6 and 8/4 instances).
module tb_strober_shift;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       d6, d8;
   logic [5:0] q6;
   logic [7:0] q8;
   int         t = 0;
   int         vectors = 0;
   int         miscompares = 0;
`ifdef STROBER_SHIFT_ENABLE_EN
   logic       en = 1'b1;
`endif

   always #5 clk = ~clk;

   strober_shift #(.WIDTH(6), .PERIOD(6)) u_dut6 (
      .clk   (clk),
      .rst_n (rst_n),
`ifdef STROBER_SHIFT_ENABLE_EN
      .en    (en),
`endif
      .d     (d6),
      .q     (q6)
   );

   strober_shift #(.WIDTH(8), .PERIOD(4)) u_dut8 (
      .clk   (clk),
      .rst_n (rst_n),
`ifdef STROBER_SHIFT_ENABLE_EN
      .en    (en),
`endif
      .d     (d8),
      .q     (q8)
   );

   // After n advancing edges, bit i holds the strobe of step n-1-i; strobe at step k is k%P==0.
   function automatic logic [7:0] model_q(input int n, input int w, input int p);
      logic [7:0] r;
      r = '0;
      for (int i = 0; i < w; i++) begin
         if ((n - 1 - i) >= 0 && ((n - 1 - i) % p) == 0) r[i] = 1'b1;
      end
      return r;
   endfunction

   function automatic logic model_d(input int n, input int p);
      return (n % p) == 0;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s t=%0d observed=%0h expected=%0h", tag, t, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, "_q6"}, 32'(q6), 32'(model_q(t, 6, 6)));
      chk({tag, "_d6"}, 32'(d6), 32'(model_d(t, 6)));
      chk({tag, "_q8"}, 32'(q8), 32'(model_q(t, 8, 4)));
      chk({tag, "_d8"}, 32'(d8), 32'(model_d(t, 4)));
   endtask

   task automatic step();
      logic adv;
      logic rst_at_edge;
`ifdef STROBER_SHIFT_ENABLE_EN
      adv = en;
`else
      adv = 1'b1;
`endif
      rst_at_edge = rst_n;
      @(posedge clk);
      #1;
      if (rst_at_edge && adv) t++;
   endtask

   initial begin : stim
      logic [5:0] walk [9];
      logic [5:0] after_rst [3];
      int highs;
      int last_high;
      walk      = '{6'd1, 6'd2, 6'd4, 6'd8, 6'd16, 6'd32, 6'd1, 6'd2, 6'd4};
      after_rst = '{6'd1, 6'd2, 6'd4};

      // Reset held with clock running
      #2;
      chk("rst_q", 32'(q6), 32'd0);
      chk("rst_d", 32'(d6), 32'd1);
      for (int i = 0; i < 3; i++) begin
         step();
         check_all("rst_hold");
      end
      rst_n = 1'b1;

      // Walking one
      for (int i = 0; i < 9; i++) begin
         step();
         chk("walk", 32'(q6), 32'(walk[i]));
         chk("onehot", 32'($countones(q6)), 32'd1);
         check_all("walk_model");
      end
      chk("w8p4", 32'(q8), 32'h11);

      // Strobe period over 36 edges
      highs = 0;
      last_high = -1;
      for (int i = 0; i < 36; i++) begin
         step();
         check_all("strobe");
         if (d6) begin
            highs++;
            if (last_high >= 0) chk("strobe_gap", 32'(i - last_high), 32'd6);
            last_high = i;
         end
      end
      chk("strobe_cnt", 32'(highs), 32'd6);

      // Mid-run async reset while q == 8
      step();
      chk("pre_rst_q", 32'(q6), 32'd8);
      rst_n = 1'b0;
      #2;
      t = 0;
      chk("async_q", 32'(q6), 32'd0);
      chk("async_d", 32'(d6), 32'd1);
      step();
      check_all("async_hold");
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("restart", 32'(q6), 32'(after_rst[i]));
         check_all("restart_model");
      end

`ifdef STROBER_SHIFT_ENABLE_EN
      en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("hold_q", 32'(q6), 32'd4);
         chk("hold_d", 32'(d6), 32'd0);
         check_all("hold_model");
      end
      en = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         check_all("resume");
      end
      chk("resume_q", 32'(q6), 32'd1);
`endif

      // Random phase: random enable and occasional mid-cycle resets
      for (int i = 0; i < 400; i++) begin
`ifdef STROBER_SHIFT_ENABLE_EN
         en = 1'($urandom_range(0, 1));
`endif
         if ($urandom_range(0, 29) == 0) begin
            rst_n = 1'b0;
            #2;
            t = 0;
            check_all("rnd_async");
            for (int k = 0; k < int'($urandom_range(1, 3)); k++) begin
               step();
               check_all("rnd_rst_hold");
            end
            rst_n = 1'b1;
         end
         step();
         check_all("rnd");
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
